// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types, opcodes and instruction field positions for alu_sequencer
package alu_seq_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_e;

    localparam int INST_W = 10;
    localparam int REG_N  = 4;

    localparam logic [3:0] OP_LOAD = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;

    localparam int OP_MSB = 9;
    localparam int OP_LSB = 6;
    localparam int RX_MSB = 5;
    localparam int RX_LSB = 4;
    localparam int RY_MSB = 3;
    localparam int RY_LSB = 2;

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction/control bundle of alu_sequencer (Step only with ALU_SEQ_STEP_EN)
interface alu_sequencer_if;
    import alu_seq_pkg::*;

    logic                Exec;
    logic [INST_W-1:0]   INST;
`ifdef ALU_SEQ_STEP_EN
    logic                Step;
`endif
    logic                IRin;
    logic                ENW;
    logic [REG_N-1:0]    Rin;
    logic [REG_N-1:0]    Rout;
    logic                Ain;
    logic                Gin;
    logic                Gout;
    logic [3:0]          FN;
    logic                Busy;
    logic                Done;

    modport slave (
        input  Exec, INST,
`ifdef ALU_SEQ_STEP_EN
        input  Step,
`endif
        output IRin, ENW, Rin, Rout, Ain, Gin, Gout, FN, Busy, Done
    );

    modport master (
        output Exec, INST,
`ifdef ALU_SEQ_STEP_EN
        output Step,
`endif
        input  IRin, ENW, Rin, Rout, Ain, Gin, Gout, FN, Busy, Done
    );

endinterface

// File: rtl/reg_decoder.sv
// rtl/reg_decoder.sv - 2-to-4 one-hot register select decoder with enable
module reg_decoder
    import alu_seq_pkg::*;
(
    input  logic             en,
    input  logic [1:0]       sel,
    output logic [REG_N-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - T0..T3 control sequencer for the 10-bit register file + ALU datapath
// Optional single-stepping of T1..T3 with macro ALU_SEQ_STEP_EN.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int IW   = 10,
    parameter int NREG = 4
) (
    input  logic               CLKb,
    input  logic               RSTb,
    alu_sequencer_if.slave     bus
);

    if (IW != 10) begin : g_bad_iw
        $error("alu_sequencer: IW must be 10");
    end
    if (NREG != 4) begin : g_bad_nreg
        $error("alu_sequencer: NREG must be 4");
    end

    state_e            state_q, state_d;
    logic [INST_W-1:0] ir_q, ir_d;

    logic [3:0] op;
    logic [1:0] rx, ry;
    logic       is_load, is_mov;
    logic       adv;
    logic       unused_rsvd;

    logic       rin_en, rout_en;
    logic [1:0] rin_sel, rout_sel;

    assign op          = ir_q[OP_MSB:OP_LSB];
    assign rx          = ir_q[RX_MSB:RX_LSB];
    assign ry          = ir_q[RY_MSB:RY_LSB];
    assign is_load     = (op == OP_LOAD);
    assign is_mov      = (op == OP_MOV);
    assign unused_rsvd = ^ir_q[1:0];

`ifdef ALU_SEQ_STEP_EN
    assign adv = bus.Step;
`else
    assign adv = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        bus.IRin = 1'b0;
        bus.ENW  = 1'b0;
        bus.Ain  = 1'b0;
        bus.Gin  = 1'b0;
        bus.Gout = 1'b0;
        bus.FN   = 4'h0;
        bus.Done = 1'b0;
        rin_en   = 1'b0;
        rin_sel  = rx;
        rout_en  = 1'b0;
        rout_sel = rx;
        unique case (state_q)
            T0: begin
                // Gated by reset so every output reads 0 while RSTb is low.
                bus.IRin = bus.Exec & RSTb;
                if (bus.Exec) begin
                    ir_d    = bus.INST;
                    state_d = T1;
                end
            end
            T1: begin
                if (is_load) begin
                    bus.ENW  = 1'b1;
                    rin_en   = 1'b1;
                    bus.Done = 1'b1;
                    if (adv) state_d = T0;
                end else if (is_mov) begin
                    rout_en  = 1'b1;
                    rout_sel = ry;
                    rin_en   = 1'b1;
                    bus.Done = 1'b1;
                    if (adv) state_d = T0;
                end else begin
                    rout_en  = 1'b1;
                    bus.Ain  = 1'b1;
                    if (adv) state_d = T2;
                end
            end
            T2: begin
                rout_en  = 1'b1;
                rout_sel = ry;
                bus.FN   = op;
                bus.Gin  = 1'b1;
                if (adv) state_d = T3;
            end
            T3: begin
                bus.Gout = 1'b1;
                rin_en   = 1'b1;
                bus.Done = 1'b1;
                if (adv) state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

    assign bus.Busy = (state_q != T0);

    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    reg_decoder u_rin_dec (
        .en     (rin_en),
        .sel    (rin_sel),
        .onehot (bus.Rin)
    );

    reg_decoder u_rout_dec (
        .en     (rout_en),
        .sel    (rout_sel),
        .onehot (bus.Rout)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed vector bench for alu_sequencer (Step sequence with ALU_SEQ_STEP_EN)
module tb_alu_sequencer;

    typedef struct {
        logic        exec;
        logic [9:0]  inst;
        logic [18:0] exp;
    } vec_t;

    logic CLKb;
    logic RSTb;
    int   checks;
    int   errors;
    vec_t vecs[$];

    alu_sequencer_if bus();

    alu_sequencer dut (
        .CLKb (CLKb),
        .RSTb (RSTb),
        .bus  (bus)
    );

    initial CLKb = 1'b1;
    always #5 CLKb = ~CLKb;

    // {IRin, ENW, Rin, Rout, Ain, Gin, Gout, FN, Busy, Done}
    function automatic logic [18:0] ev(input logic irin, input logic enw,
                                       input logic [3:0] rin, input logic [3:0] rout,
                                       input logic ain, input logic gin, input logic gout,
                                       input logic [3:0] fn, input logic busy, input logic done);
        return {irin, enw, rin, rout, ain, gin, gout, fn, busy, done};
    endfunction

    function automatic logic [18:0] outs();
        return {bus.IRin, bus.ENW, bus.Rin, bus.Rout, bus.Ain, bus.Gin, bus.Gout,
                bus.FN, bus.Busy, bus.Done};
    endfunction

    task automatic check(input string name, input logic [18:0] exp);
        logic [18:0] got;
        got = outs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic add(input logic exec, input logic [9:0] inst, input logic [18:0] exp);
        vec_t v;
        v.exec = exec;
        v.inst = inst;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    localparam logic [18:0] IDLE = 19'd0;

    initial begin
        checks   = 0;
        errors   = 0;
        RSTb     = 1'b0;
        bus.Exec = 1'b1;
        bus.INST = 10'b0010_00_01_00;
`ifdef ALU_SEQ_STEP_EN
        bus.Step = 1'b1;
`endif

        // LOAD R2
        add(0, 10'b0000_00_00_00, IDLE);
        add(1, 10'b0000_10_00_00, ev(1,0,4'b0000,4'b0000,0,0,0,4'h0,0,0));
        add(0, 10'b0000_00_00_00, ev(0,1,4'b0100,4'b0000,0,0,0,4'h0,1,1));
        add(0, 10'b0000_00_00_00, IDLE);
        // MOV R1 <- R3
        add(1, 10'b0001_01_11_00, ev(1,0,4'b0000,4'b0000,0,0,0,4'h0,0,0));
        add(0, 10'b0000_00_00_00, ev(0,0,4'b0010,4'b1000,0,0,0,4'h0,1,1));
        // ADD R0 <- R0 + R1, INST changed during T2 with Exec held
        add(1, 10'b0010_00_01_00, ev(1,0,4'b0000,4'b0000,0,0,0,4'h0,0,0));
        add(1, 10'b0010_00_01_00, ev(0,0,4'b0000,4'b0001,1,0,0,4'h0,1,0));
        add(1, 10'b0011_11_10_00, ev(0,0,4'b0000,4'b0010,0,1,0,4'h2,1,0));
        add(1, 10'b0011_11_10_00, ev(0,0,4'b0001,4'b0000,0,0,1,4'h0,1,1));
        add(1, 10'b0011_11_10_00, ev(1,0,4'b0000,4'b0000,0,0,0,4'h0,0,0));
        add(0, 10'b0000_00_00_00, ev(0,0,4'b0000,4'b1000,1,0,0,4'h0,1,0));
        add(0, 10'b0000_00_00_00, ev(0,0,4'b0000,4'b0100,0,1,0,4'h3,1,0));
        add(0, 10'b0000_00_00_00, ev(0,0,4'b1000,4'b0000,0,0,1,4'h0,1,1));
        add(0, 10'b0000_00_00_00, IDLE);
        // MOV R2 <- R2, reserved bits set
        add(1, 10'b0001_10_10_11, ev(1,0,4'b0000,4'b0000,0,0,0,4'h0,0,0));
        add(0, 10'b0000_00_00_00, ev(0,0,4'b0100,4'b0100,0,0,0,4'h0,1,1));
        add(0, 10'b0000_00_00_00, IDLE);
        // opcode F: R1 <- R1 F R0
        add(1, 10'b1111_01_00_01, ev(1,0,4'b0000,4'b0000,0,0,0,4'h0,0,0));
        add(0, 10'b0000_00_00_00, ev(0,0,4'b0000,4'b0010,1,0,0,4'h0,1,0));
        add(0, 10'b0000_00_00_00, ev(0,0,4'b0000,4'b0001,0,1,0,4'hF,1,0));
        add(0, 10'b0000_00_00_00, ev(0,0,4'b0010,4'b0000,0,0,1,4'h0,1,1));
        add(0, 10'b0000_00_00_00, IDLE);
        // back-to-back LOAD R3 with Exec held
        add(1, 10'b0000_11_00_00, ev(1,0,4'b0000,4'b0000,0,0,0,4'h0,0,0));
        add(1, 10'b0000_11_00_00, ev(0,1,4'b1000,4'b0000,0,0,0,4'h0,1,1));
        add(1, 10'b0000_11_00_00, ev(1,0,4'b0000,4'b0000,0,0,0,4'h0,0,0));
        add(0, 10'b0000_00_00_00, ev(0,1,4'b1000,4'b0000,0,0,0,4'h0,1,1));
        add(0, 10'b0000_00_00_00, IDLE);

        @(posedge CLKb);
        #1 check("reset_outputs", IDLE);
        RSTb     = 1'b1;
        bus.Exec = 1'b0;

        foreach (vecs[i]) begin
            @(posedge CLKb);
            bus.Exec = vecs[i].exec;
            bus.INST = vecs[i].inst;
            #1 check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset asserted during T2 of an ALU op
        @(posedge CLKb);
        bus.Exec = 1'b1;
        bus.INST = 10'b0010_00_01_00;
        #1 check("rst_mid_accept", ev(1,0,4'b0000,4'b0000,0,0,0,4'h0,0,0));
        @(posedge CLKb);
        #1 check("rst_mid_t1", ev(0,0,4'b0000,4'b0001,1,0,0,4'h0,1,0));
        @(posedge CLKb);
        #1 check("rst_mid_t2", ev(0,0,4'b0000,4'b0010,0,1,0,4'h2,1,0));
        #1 RSTb = 1'b0;
        #1 check("rst_mid_async", IDLE);
        @(posedge CLKb);
        #1 check("rst_mid_held", IDLE);
        bus.Exec = 1'b0;
        RSTb     = 1'b1;
        @(posedge CLKb);
        #1 check("rst_mid_idle0", IDLE);
        @(posedge CLKb);
        #1 check("rst_mid_idle1", IDLE);

`ifdef ALU_SEQ_STEP_EN
        @(posedge CLKb);
        bus.Exec = 1'b1;
        bus.INST = 10'b0010_00_01_00;
        bus.Step = 1'b1;
        #1 check("step_accept", ev(1,0,4'b0000,4'b0000,0,0,0,4'h0,0,0));
        @(posedge CLKb);
        bus.Exec = 1'b0;
        #1 check("step_t1", ev(0,0,4'b0000,4'b0001,1,0,0,4'h0,1,0));
        for (int k = 0; k < 3; k++) begin
            @(posedge CLKb);
            bus.Step = 1'b0;
            #1 check($sformatf("step_hold%0d", k), ev(0,0,4'b0000,4'b0010,0,1,0,4'h2,1,0));
        end
        @(posedge CLKb);
        bus.Step = 1'b1;
        #1 check("step_release_t2", ev(0,0,4'b0000,4'b0010,0,1,0,4'h2,1,0));
        @(posedge CLKb);
        #1 check("step_t3", ev(0,0,4'b0001,4'b0000,0,0,1,4'h0,1,1));
        @(posedge CLKb);
        #1 check("step_idle", IDLE);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
